// File: rtl/skewed_transpose_buffer_pkg.sv
// Shared types and sizing helpers for the skewed transpose buffer.
// The drain length grows with the skew because the last row starts DIM-1 steps late.
package transpose_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   function automatic int drain_len(input int dim, input int skew);
      return dim + skew * (dim - 1);
   endfunction

   // Pointer width that never collapses to zero bits for a single-entry structure.
   function automatic int ptr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/skewed_transpose_buffer_if.sv
// Row-write handshake plus the parallel skewed drain bus of the transpose buffer.
// A row transfers on any clock edge where wr_vld && wr_rdy; wr_vld may stay high across rows and wr_rdy never depends on wr_vld.
interface skewed_transpose_buffer_if #(
   parameter int DIM  = 8,
   parameter int BITS = 8
);
   logic                      wr_vld;
   logic                      wr_rdy;
   logic [DIM-1:0][BITS-1:0]  wr_row;
   logic                      en;
   logic [DIM-1:0][BITS-1:0]  q;
   logic [DIM-1:0]            q_vld;
   logic                      busy;
   logic                      done;

   modport master (
      output wr_vld, wr_row, en,
      input  wr_rdy, q, q_vld, busy, done
   );

   modport slave (
      input  wr_vld, wr_row, en,
      output wr_rdy, q, q_vld, busy, done
   );
endinterface

// File: rtl/skewed_transpose_buffer_bank.sv
// One DIM x DIM storage bank: full-row write port, per-row element read at a row-specific column.
// Contents are not reset; the owner's full flags decide whether the data means anything.
module tb_bank
   import transpose_pkg::*;
#(
   parameter int DIM  = 8,
   parameter int BITS = 8
) (
   input  logic                              clk,
   input  logic                              we_i,
   input  logic [ptr_w(DIM)-1:0]             row_i,
   input  logic [DIM-1:0][BITS-1:0]          data_i,
   input  logic [DIM-1:0][ptr_w(DIM)-1:0]    rd_k_i,
   output logic [DIM-1:0][BITS-1:0]          rd_o
);
   logic [DIM-1:0][DIM-1:0][BITS-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[row_i] <= data_i;
      end
   end

   always_comb begin
      rd_o = '0;
      for (int i = 0; i < DIM; i++) begin
         rd_o[i] = mem_q[i][rd_k_i[i]];
      end
   end
endmodule

// File: rtl/skewed_transpose_buffer.sv
// Ping-pong DIM x DIM transpose buffer: rows are written whole, then every row streams out
// in parallel, one element per enabled step, with row i optionally delayed by i steps.
module skewed_transpose_buffer
   import transpose_pkg::*;
#(
   parameter int DIM  = 8,
   parameter int BITS = 8,
   parameter int SKEW = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   skewed_transpose_buffer_if.slave   bus,
   output state_t                     state_o
);
   localparam int L      = drain_len(DIM, SKEW);
   localparam int STEP_W = $clog2(L + 1);
   localparam int PW     = ptr_w(DIM);
   localparam int KW     = STEP_W + 1;

   typedef logic [DIM-1:0][BITS-1:0] row_t;

   state_t               state_q;
   logic [1:0]           full_q;
   logic                 fill_sel_q;
   logic                 drain_sel_q;
   logic [PW-1:0]        wr_ptr_q;
   logic [STEP_W-1:0]    step_q;
   row_t                 q_q;
   logic [DIM-1:0]       q_vld_q;
   logic                 done_q;

   logic                 wr_rdy;
   logic                 wr_fire;
   logic                 fill_last;
   logic                 other_full;
   logic signed [KW-1:0] k_s [DIM];
   logic [DIM-1:0][PW-1:0] rd_k;
   row_t                 rd0;
   row_t                 rd1;
   row_t                 q_d;
   logic [DIM-1:0]       q_vld_d;

   assign wr_rdy    = !full_q[fill_sel_q];
   assign wr_fire   = bus.wr_vld && wr_rdy;
   assign fill_last = wr_fire && (wr_ptr_q == PW'(DIM - 1));
   // A bank completing on the same edge as the final drain step counts as ready, so no bubble.
   assign other_full = full_q[!drain_sel_q] || (fill_last && (fill_sel_q != drain_sel_q));

   tb_bank #(.DIM(DIM), .BITS(BITS)) u_bank0 (
      .clk    (clk),
      .we_i   (wr_fire && !fill_sel_q),
      .row_i  (wr_ptr_q),
      .data_i (bus.wr_row),
      .rd_k_i (rd_k),
      .rd_o   (rd0)
   );

   tb_bank #(.DIM(DIM), .BITS(BITS)) u_bank1 (
      .clk    (clk),
      .we_i   (wr_fire && fill_sel_q),
      .row_i  (wr_ptr_q),
      .data_i (bus.wr_row),
      .rd_k_i (rd_k),
      .rd_o   (rd1)
   );

   always_comb begin
      k_s     = '{default: '0};
      rd_k    = '0;
      q_d     = '0;
      q_vld_d = '0;
      for (int i = 0; i < DIM; i++) begin
         k_s[i]     = $signed({1'b0, step_q}) - $signed(KW'(SKEW * i));
         rd_k[i]    = k_s[i][PW-1:0];
         q_vld_d[i] = !k_s[i][KW-1] && (k_s[i] < $signed(KW'(DIM)));
         q_d[i]     = q_vld_d[i] ? (drain_sel_q ? rd1[i] : rd0[i]) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         full_q      <= '0;
         fill_sel_q  <= 1'b0;
         drain_sel_q <= 1'b0;
         wr_ptr_q    <= '0;
         step_q      <= '0;
         q_q         <= '0;
         q_vld_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         if (wr_fire) begin
            if (fill_last) begin
               full_q[fill_sel_q] <= 1'b1;
               wr_ptr_q           <= '0;
               fill_sel_q         <= !fill_sel_q;
            end else begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
            end
         end

         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               q_q     <= '0;
               q_vld_q <= '0;
               step_q  <= '0;
               if (full_q[drain_sel_q]) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.en) begin
                  q_q     <= q_d;
                  q_vld_q <= q_vld_d;
                  if (step_q == STEP_W'(L - 1)) begin
                     done_q              <= 1'b1;
                     full_q[drain_sel_q] <= 1'b0;
                     drain_sel_q         <= !drain_sel_q;
                     step_q              <= '0;
                     state_q             <= other_full ? DRAIN : IDLE;
                  end else begin
                     step_q <= step_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.wr_rdy = wr_rdy;
   assign bus.q      = q_q;
   assign bus.q_vld  = q_vld_q;
   assign bus.busy   = (state_q == DRAIN);
   assign bus.done   = done_q;
   assign state_o    = state_q;
endmodule

// File: tb/tb_skewed_transpose_buffer.sv
// Bench for the skewed transpose buffer: an unskewed and a skewed instance, each checked
// cycle by cycle against expected drain vectors queued when a bank's last row is accepted.
module tb_skewed_transpose_buffer;
   import transpose_pkg::*;

   localparam int DIM  = 4;
   localparam int BITS = 8;
   localparam int EW   = 1 + DIM + DIM * BITS;
   localparam int L1   = DIM + (DIM - 1);

   typedef logic [DIM-1:0][BITS-1:0] row_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   skewed_transpose_buffer_if #(.DIM(DIM), .BITS(BITS)) a_if ();
   skewed_transpose_buffer_if #(.DIM(DIM), .BITS(BITS)) b_if ();
   state_t st_a;
   state_t st_b;

   skewed_transpose_buffer #(.DIM(DIM), .BITS(BITS), .SKEW(0)) dut_a (
      .clk(clk), .rst(rst), .bus(a_if), .state_o(st_a)
   );

   skewed_transpose_buffer #(.DIM(DIM), .BITS(BITS), .SKEW(1)) dut_b (
      .clk(clk), .rst(rst), .bus(b_if), .state_o(st_b)
   );

   // scoreboard
   int              n_checks = 0;
   int              n_fail   = 0;
   logic [EW-1:0]   exp_q0[$];
   logic [EW-1:0]   exp_q1[$];
   row_t            pend0[$];
   row_t            pend1[$];
   bit              rst_prev = 1'b1;
   bit              fire_a   = 1'b0;
   bit              fire_b   = 1'b0;
   bit              busy_pa  = 1'b0;
   bit              busy_pb  = 1'b0;
   logic [EW-1:0]   last_a   = '0;
   logic [EW-1:0]   last_b   = '0;
   logic [EW-1:0]   got_a;
   logic [EW-1:0]   got_b;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic row_t mk_row(input int r, input int base);
      row_t x;
      for (int c = 0; c < DIM; c++) x[c] = BITS'(base + 16 * r + c);
      return x;
   endfunction

   function automatic row_t rand_row();
      row_t x;
      for (int c = 0; c < DIM; c++) x[c] = BITS'($urandom_range(0, 255));
      return x;
   endfunction

   // Expected drain of one matrix: step s shows element s-skew*i of row i, done on the last step.
   task automatic push_bank(input int sel, input int skew);
      row_t           m [DIM];
      row_t           qv;
      logic [DIM-1:0] vv;
      int             len;
      int             k;
      for (int r = 0; r < DIM; r++) m[r] = (sel == 0) ? pend0.pop_front() : pend1.pop_front();
      len = DIM + skew * (DIM - 1);
      for (int s = 0; s < len; s++) begin
         qv = '0;
         vv = '0;
         for (int i = 0; i < DIM; i++) begin
            k = s - skew * i;
            if (k >= 0 && k < DIM) begin
               qv[i] = m[i][k];
               vv[i] = 1'b1;
            end
         end
         if (sel == 0) exp_q0.push_back({(s == len - 1), vv, qv});
         else          exp_q1.push_back({(s == len - 1), vv, qv});
      end
   endtask

   // Monitor: outputs change only after an enabled drain step; otherwise they hold, or read zero after idle/reset.
   always @(negedge clk) begin
      got_a = {a_if.done, a_if.q_vld, a_if.q};
      got_b = {b_if.done, b_if.q_vld, b_if.q};
      if (rst_prev) check("a_reset_out", got_a, '0);
      else if (fire_a) begin
         if (exp_q0.size() == 0) check("a_sb_empty", exp_q0.size(), 1);
         else check("a_step_out", got_a, exp_q0.pop_front());
      end else check("a_hold_out", got_a, busy_pa ? {1'b0, last_a[EW-2:0]} : '0);
      if (rst_prev) check("b_reset_out", got_b, '0);
      else if (fire_b) begin
         if (exp_q1.size() == 0) check("b_sb_empty", exp_q1.size(), 1);
         else check("b_step_out", got_b, exp_q1.pop_front());
      end else check("b_hold_out", got_b, busy_pb ? {1'b0, last_b[EW-2:0]} : '0);
      last_a   = got_a;
      last_b   = got_b;
      fire_a   = a_if.en && a_if.busy && !rst;
      fire_b   = b_if.en && b_if.busy && !rst;
      busy_pa  = a_if.busy;
      busy_pb  = b_if.busy;
      rst_prev = rst;
   end

   // Drivers. mode 1: row must be accepted at once; mode 2: refused first, then accepted in the done cycle.
   task automatic b_write(input row_t r, input int mode);
      int n;
      n = 0;
      b_if.wr_vld = 1'b1;
      b_if.wr_row = r;
      if (mode == 1) check("wr_rdy_now", b_if.wr_rdy, 1);
      if (mode == 2) check("wr_refused", b_if.wr_rdy, 0);
      while (!b_if.wr_rdy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("wr_in_time", (n < 100), 1);
      if (mode == 2) begin
         check("rdy_with_done", b_if.done, 1);
         check("no_bubble", b_if.busy, 1);
      end
      if (n < 100) begin
         @(posedge clk); #1;
         pend1.push_back(r);
         if (pend1.size() == DIM) push_bank(1, 1);
      end
      b_if.wr_vld = 1'b0;
   endtask

   task automatic wait_idle(input int sel);
      int n;
      n = 0;
      while (((sel == 0) ? (exp_q0.size() != 0 || a_if.busy) : (exp_q1.size() != 0 || b_if.busy))
             && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_in_time", (n < 200), 1);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int steps;
      a_if.wr_vld = 1'b0;
      a_if.wr_row = '0;
      a_if.en     = 1'b1;
      b_if.wr_vld = 1'b0;
      b_if.wr_row = '0;
      b_if.en     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_wr_rdy", b_if.wr_rdy, 1);
      check("rst_busy", b_if.busy, 0);
      check("rst_done", b_if.done, 0);
      check("rst_state", st_b, IDLE);
      check("rst_a_wr_rdy", a_if.wr_rdy, 1);

      // aligned drain
      for (int r = 0; r < DIM; r++) begin
         a_if.wr_vld = 1'b1;
         a_if.wr_row = mk_row(r, 0);
         check("t1_wr_rdy", a_if.wr_rdy, 1);
         @(posedge clk); #1;
         pend0.push_back(mk_row(r, 0));
      end
      a_if.wr_vld = 1'b0;
      push_bank(0, 0);
      check("t1_idle_first", a_if.busy, 0);
      @(posedge clk); #1;
      check("t1_busy_rise", a_if.busy, 1);
      wait_idle(0);
      check("t1_busy_end", a_if.busy, 0);

      // skewed drain of the same matrix
      for (int r = 0; r < DIM; r++) b_write(mk_row(r, 0), 1);
      wait_idle(1);

      // ping-pong: two banks back to back, ninth row waits for the first done
      for (int r = 0; r < 2 * DIM; r++) b_write(rand_row(), 1);
      b_write(rand_row(), 2);
      for (int r = 1; r < DIM; r++) b_write(rand_row(), 0);
      wait_idle(1);

      // en stalls in a 1,0,0,1 pattern
      for (int r = 0; r < DIM; r++) b_write(mk_row(r, 8'h80), 1);
      steps = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         b_if.en = ((cyc % 4) == 1 || (cyc % 4) == 2) ? 1'b0 : 1'b1;
         if (b_if.en && b_if.busy) steps++;
         @(posedge clk); #1;
         if (b_if.done) break;
      end
      check("t4_enabled_steps", steps, L1);
      b_if.en = 1'b1;
      wait_idle(1);

      // reset in place of drain step 2
      for (int r = 0; r < DIM; r++) b_write(mk_row(r, 8'h08), 1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5_busy", b_if.busy, 0);
      check("t5_wr_rdy", b_if.wr_rdy, 1);
      check("t5_q", {b_if.q_vld, b_if.q}, '0);
      check("t5_state", st_b, IDLE);
      exp_q1.delete();
      pend1.delete();
      for (int r = 0; r < DIM; r++) b_write(mk_row(r, 8'h0a), 1);
      wait_idle(1);

      // fill of one bank completes on the same edge as the final drain step of the other
      for (int r = 0; r < DIM; r++) b_write(rand_row(), 1);
      for (int r = 0; r < DIM - 1; r++) b_write(rand_row(), 1);
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("t6_no_early_done", b_if.done, 0);
      b_write(rand_row(), 1);
      check("t6_done", b_if.done, 1);
      check("t6_no_bubble", b_if.busy, 1);
      check("t6_rdy_after_free", b_if.wr_rdy, 1);
      for (int r = 0; r < DIM; r++) b_write(rand_row(), 1);
      wait_idle(1);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
